// File: rtl/encrypt_core.sv
// encrypt_core: iterative SPECK block cipher, one round per clock with an on-the-fly key schedule.
// The ciphertext register only updates on the final round, so it never exposes intermediate state.
module encrypt_core #(
    parameter int BLOCK_SIZE = 64,
    parameter int KEY_SIZE   = 128,
    parameter int NR_ROUNDS  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_SIZE-1:0] plaintext,
    input  logic [KEY_SIZE-1:0] key,
    output logic [KEY_SIZE-1:0] ciphertext,
    output logic                active,
    output logic                ready
);
    localparam int CW = $clog2(NR_ROUNDS + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                state_q, state_d;
    logic [BLOCK_SIZE-1:0] x_q, x_d, y_q, y_d, l_q, l_d, k_q, k_d;
    logic [BLOCK_SIZE-1:0] x_new, y_new, l_new, k_new;
    logic [CW-1:0]         ctr_q, ctr_d;
    logic [KEY_SIZE-1:0]   ct_q, ct_d;
    function automatic logic [BLOCK_SIZE-1:0] ror8(input logic [BLOCK_SIZE-1:0] v);
        return {v[7:0], v[BLOCK_SIZE-1:8]};
    endfunction
    function automatic logic [BLOCK_SIZE-1:0] rol3(input logic [BLOCK_SIZE-1:0] v);
        return {v[BLOCK_SIZE-4:0], v[BLOCK_SIZE-1:BLOCK_SIZE-3]};
    endfunction
    assign x_new = (ror8(x_q) + y_q) ^ k_q;
    assign y_new = rol3(y_q) ^ x_new;
    assign l_new = (ror8(l_q) + k_q) ^ BLOCK_SIZE'(ctr_q);
    assign k_new = rol3(k_q) ^ l_new;
    assign ciphertext = ct_q;
    assign active = state_q == RUN;
    assign ready = state_q == DONE;
    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        l_d = l_q;
        k_d = k_q;
        ctr_d = ctr_q;
        ct_d = ct_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                x_d = plaintext[KEY_SIZE-1:BLOCK_SIZE];
                y_d = plaintext[BLOCK_SIZE-1:0];
                l_d = key[KEY_SIZE-1:BLOCK_SIZE];
                k_d = key[BLOCK_SIZE-1:0];
                ctr_d = '0;
            end
            RUN: begin
                x_d = x_new;
                y_d = y_new;
                l_d = l_new;
                k_d = k_new;
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == CW'(NR_ROUNDS - 1)) begin
                    state_d = DONE;
                    ct_d = {x_new, y_new};
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            l_q <= '0;
            k_q <= '0;
            ctr_q <= '0;
            ct_q <= '0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            l_q <= l_d;
            k_q <= k_d;
            ctr_q <= ctr_d;
            ct_q <= ct_d;
        end
    end
endmodule
